// File: rtl/cva6v_config_pkg.sv
// ---------------------------------------------------------------------------
// cva6v_config_pkg
// Minimal core-configuration package. The serializer only needs the number
// of commit ports, so the configuration record carries just that field.
// cva6_cfg_empty is the default configuration (two commit ports).
// ---------------------------------------------------------------------------
package cva6v_config_pkg;

   typedef struct packed {
      int unsigned NrCommitPorts;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '{NrCommitPorts: 32'd2};

endpackage

// File: rtl/rvfi_serializer_pkg.sv
// ---------------------------------------------------------------------------
// rvfi_serializer_pkg
// Shared types and helpers for the RVFI commit serializer:
//   order_t              - 32-bit running order number (wraps modulo 2^32)
//   DROP_SAT             - saturation value of the dropped-entry counter
//   rvfi_instr_default_t - default RVFI per-instruction packet
//   popcount_live()      - number of live commit ports in a liveness mask
//   slot_index()         - compacted slot of a port (live ports below it)
// Helpers work on a liveness mask padded to MAX_PORTS bits so they do not
// depend on the packet type.
// ---------------------------------------------------------------------------
package rvfi_serializer_pkg;

   typedef logic [31:0] order_t;
   localparam order_t DROP_SAT = 32'hFFFF_FFFF;

   localparam int unsigned MAX_PORTS  = 8;
   localparam int unsigned PORT_CNT_W = $clog2(MAX_PORTS + 1);

   typedef logic [MAX_PORTS-1:0]  live_mask_t;
   typedef logic [PORT_CNT_W-1:0] port_cnt_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] order;
      logic [31:0] insn;
      logic        trap;
      logic        halt;
      logic        intr;
      logic [1:0]  mode;
      logic [63:0] pc_rdata;
      logic [63:0] pc_wdata;
   } rvfi_instr_default_t;

   function automatic port_cnt_t popcount_live(input live_mask_t live);
      port_cnt_t n;
      n = '0;
      for (int unsigned i = 0; i < MAX_PORTS; i++) begin
         n = n + port_cnt_t'(live[i]);
      end
      return n;
   endfunction

   // Slot a live port lands in after gaps are squeezed out: the number of
   // live ports with a lower index.
   function automatic port_cnt_t slot_index(input live_mask_t live, input int unsigned port);
      port_cnt_t n;
      n = '0;
      for (int unsigned i = 0; i < MAX_PORTS; i++) begin
         if (i < port) begin
            n = n + port_cnt_t'(live[i]);
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/rvfi_mw_fifo.sv
// ---------------------------------------------------------------------------
// rvfi_mw_fifo
// Multi-write, single-read circular buffer. Up to NrWr entries are written
// per cycle from wr_data[0 .. wr_num-1] into consecutive slots; one entry is
// popped when rd_en is high. The caller guarantees wr_num never exceeds the
// free space and rd_en is only raised when count != 0.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   wr_num        number of entries to write this cycle
//   wr_data       compacted write entries
//   rd_en         pop the head entry
//   rd_data       head entry (meaningful while count != 0)
//   count         current occupancy
// ---------------------------------------------------------------------------
module rvfi_mw_fifo #(
   parameter int unsigned NrWr  = 2,
   parameter int unsigned Depth = 16,
   parameter type entry_t = logic [31:0],
   localparam int unsigned NumW = $clog2(NrWr + 1),
   localparam int unsigned CntW = $clog2(Depth) + 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [NumW-1:0] wr_num,
   input  entry_t          wr_data [NrWr],
   input  logic            rd_en,
   output entry_t          rd_data,
   output logic [CntW-1:0] count
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   entry_t          mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;

   // Pointers are exactly log2(Depth) bits, so plain addition wraps.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PtrW'(wr_num);
      rd_ptr_d = rd_ptr_q + PtrW'(rd_en);
      count_d  = count_q + CntW'(wr_num) - CntW'(rd_en);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; the count alone decides which slots hold data.
   always_ff @(posedge clk_i) begin
      for (int unsigned j = 0; j < NrWr; j++) begin
         if (j < 32'(wr_num)) begin
            mem_q[wr_ptr_q + PtrW'(j)] <= wr_data[j];
         end
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;

endmodule

// File: rtl/rvfi_commit_serializer.sv
// ---------------------------------------------------------------------------
// rvfi_commit_serializer
// Turns the core's multi-port RVFI commit interface into a single
// valid/ready stream. Live ports (valid or trap) are compacted in port
// order, stamped with a running order number and buffered. The core cannot
// be stalled, so entries that do not fit are dropped and counted.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   rvfi_i        commit ports from the core
//   valid_o       head entry available
//   ready_i       consumer accepts head
//   rvfi_o        head entry
//   order_o       order number of head entry
//   count_o       current occupancy
//   overflow_o    sticky: at least one entry dropped since reset
//   dropped_o     dropped-entry count, saturating
// ---------------------------------------------------------------------------
module rvfi_commit_serializer
   import rvfi_serializer_pkg::*;
#(
   parameter cva6v_config_pkg::cva6_cfg_t CVA6Cfg = cva6v_config_pkg::cva6_cfg_empty,
   parameter type rvfi_instr_t = rvfi_instr_default_t,
   parameter int unsigned Depth = 16,
   localparam int unsigned NrPorts = CVA6Cfg.NrCommitPorts,
   localparam int unsigned CntW    = $clog2(Depth) + 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  rvfi_instr_t     rvfi_i [NrPorts],
   output logic            valid_o,
   input  logic            ready_i,
   output rvfi_instr_t     rvfi_o,
   output order_t          order_o,
   output logic [CntW-1:0] count_o,
   output logic            overflow_o,
   output logic [31:0]     dropped_o
);

   localparam int unsigned NumW = $clog2(NrPorts + 1);

   typedef struct packed {
      rvfi_instr_t instr;
      order_t      order;
   } entry_t;

   live_mask_t      live;
   port_cnt_t       n_live;
   logic [31:0]     live_w, free_w, push_w, drop_w;
   entry_t          wr_data [NrPorts];
   entry_t          rd_data;
   logic [NumW-1:0] wr_num;
   logic            rd_en;
   logic [CntW-1:0] count;
   logic [32:0]     dropped_sum;

   order_t          order_q, order_d;
   logic            overflow_q, overflow_d;
   logic [31:0]     dropped_q, dropped_d;

   // Liveness mask, padded with zeros up to the helper width.
   for (genvar gi = 0; gi < MAX_PORTS; gi++) begin : g_live
      if (gi < NrPorts) begin : g_port
         assign live[gi] = rvfi_i[gi].valid | rvfi_i[gi].trap;
      end else begin : g_pad
         assign live[gi] = 1'b0;
      end
   end

   assign n_live = popcount_live(live);

   // Compaction: each live port goes to the slot equal to the number of
   // live ports below it. Slots beyond wr_num are ignored by the FIFO, so
   // the order stamp can be order_q + slot unconditionally.
   always_comb begin
      for (int unsigned s = 0; s < NrPorts; s++) begin
         wr_data[s]       = '0;
         wr_data[s].order = order_q + order_t'(s);
         for (int unsigned p = 0; p < NrPorts; p++) begin
            if (live[p] && (slot_index(live, p) == port_cnt_t'(s))) begin
               wr_data[s].instr = rvfi_i[p];
            end
         end
      end
   end

   // Space is measured against the occupancy at the start of the cycle;
   // a pop in the same cycle frees nothing for this cycle's pushes.
   always_comb begin
      live_w      = 32'(n_live);
      free_w      = Depth - 32'(count);
      push_w      = (live_w < free_w) ? live_w : free_w;
      drop_w      = live_w - push_w;
      wr_num      = NumW'(push_w);
      rd_en       = valid_o & ready_i;
      order_d     = order_q + push_w;
      overflow_d  = overflow_q | (drop_w != 32'd0);
      dropped_sum = {1'b0, dropped_q} + {1'b0, drop_w};
      dropped_d   = dropped_sum[32] ? DROP_SAT : dropped_sum[31:0];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         order_q    <= '0;
         overflow_q <= 1'b0;
         dropped_q  <= '0;
      end else begin
         order_q    <= order_d;
         overflow_q <= overflow_d;
         dropped_q  <= dropped_d;
      end
   end

   rvfi_mw_fifo #(
      .NrWr    (NrPorts),
      .Depth   (Depth),
      .entry_t (entry_t)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .wr_num  (wr_num),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .count   (count)
   );

   assign valid_o    = (count != '0);
   assign rvfi_o     = rd_data.instr;
   assign order_o    = rd_data.order;
   assign count_o    = count;
   assign overflow_o = overflow_q;
   assign dropped_o  = dropped_q;

endmodule
